// File: rtl/pipe_pkg.sv
// ============================================================================
// Module      : pipe_pkg
// Description : Shared pipeline definitions: next-PC select codes, fetch state
//               encodings, reset PC and bubble instruction.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

    localparam logic [1:0] c_PCSRC_SEQ = 2'b00;  // pc + 4
    localparam logic [1:0] c_PCSRC_BR  = 2'b01;  // branch target
    localparam logic [1:0] c_PCSRC_JR  = 2'b10;  // register jump
    localparam logic [1:0] c_PCSRC_J   = 2'b11;  // jump target

    localparam logic [1:0] c_ST_FETCH   = 2'b00;
    localparam logic [1:0] c_ST_HOLD    = 2'b01;
    localparam logic [1:0] c_ST_DISCARD = 2'b10;

    localparam logic [31:0] c_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] c_NOP_INST = 32'h0000_0000;  // sll $0,$0,0

    typedef enum logic [1:0] {
        ST_FETCH   = c_ST_FETCH,
        ST_HOLD    = c_ST_HOLD,
        ST_DISCARD = c_ST_DISCARD
    } fetch_state_t;

endpackage : pipe_pkg

`default_nettype wire

// File: rtl/pipe_npc_mux.sv
// ============================================================================
// Module      : pipe_npc_mux
// Description : 4:1 32-bit next-PC selector driven by the ID-stage pcsource.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_npc_mux
    import pipe_pkg::*;
(
    input  logic [1:0]  sel,
    input  logic [31:0] pc4,
    input  logic [31:0] bpc,
    input  logic [31:0] da,
    input  logic [31:0] jpc,
    output logic [31:0] npc
);

    always_comb begin
        npc = pc4;
        case (sel)
            c_PCSRC_SEQ: npc = pc4;
            c_PCSRC_BR:  npc = bpc;
            c_PCSRC_JR:  npc = da;
            c_PCSRC_J:   npc = jpc;
            default:     npc = pc4;
        endcase
    end

endmodule : pipe_npc_mux

`default_nettype wire

// File: rtl/pipe_fetch.sv
// ============================================================================
// Module      : pipe_fetch
// Description : IF stage with variable-latency instruction memory, stall
//               buffer, flushed redirects and delayed-branch support.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_fetch
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = c_RESET_PC,
    parameter logic [31:0] NOP_INST = c_NOP_INST
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] da,
    input  logic [31:0] jpc,
    input  logic        wpcir,
    input  logic        if_flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] dpc4,
    output logic [31:0] inst,
    output logic        dvalid
);

    fetch_state_t r_state, w_state_nxt;
    logic [31:0]  r_pc, w_pc_nxt;
    logic [31:0]  r_saved, w_saved_nxt;
    logic         r_pending, w_pending_nxt;
    logic [31:0]  r_hold_inst, w_hold_inst_nxt;
    logic [31:0]  r_hold_pc4, w_hold_pc4_nxt;
    logic [31:0]  r_inst, w_inst_nxt;
    logic [31:0]  r_dpc4, w_dpc4_nxt;
    logic         r_dvalid, w_dvalid_nxt;

    logic [31:0]  w_pc4;
    logic [31:0]  w_npc;
    logic         w_redirect;
    logic         w_avail;
    logic [31:0]  w_acc_inst;
    logic [31:0]  w_acc_pc4;

    assign w_pc4      = r_pc + 32'd4;
    assign w_redirect = (pcsource != c_PCSRC_SEQ);
    assign w_avail    = ((r_state == ST_FETCH) && imem_ready) || (r_state == ST_HOLD);
    assign w_acc_inst = (r_state == ST_HOLD) ? r_hold_inst : imem_rdata;
    assign w_acc_pc4  = (r_state == ST_HOLD) ? r_hold_pc4  : w_pc4;

    pipe_npc_mux u_npc_mux (
        .sel (pcsource),
        .pc4 (w_pc4),
        .bpc (bpc),
        .da  (da),
        .jpc (jpc),
        .npc (w_npc)
    );

    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_saved_nxt     = r_saved;
        w_pending_nxt   = r_pending;
        w_hold_inst_nxt = r_hold_inst;
        w_hold_pc4_nxt  = r_hold_pc4;
        w_inst_nxt      = r_inst;
        w_dpc4_nxt      = r_dpc4;
        w_dvalid_nxt    = r_dvalid;

        case (r_state)
            ST_FETCH, ST_HOLD: begin
                if (!wpcir) begin
                    // ID stalled: park a completing fetch until ID can take it
                    if ((r_state == ST_FETCH) && imem_ready) begin
                        w_hold_inst_nxt = imem_rdata;
                        w_hold_pc4_nxt  = w_pc4;
                        w_state_nxt     = ST_HOLD;
                    end
                end else if (w_redirect && if_flush) begin
                    w_inst_nxt    = NOP_INST;
                    w_dvalid_nxt  = 1'b0;
                    w_pending_nxt = 1'b0;
                    if (w_avail) begin
                        w_pc_nxt    = w_npc;
                        w_state_nxt = ST_FETCH;
                    end else begin
                        w_saved_nxt = w_npc;
                        w_state_nxt = ST_DISCARD;
                    end
                end else if (w_avail) begin
                    w_inst_nxt    = w_acc_inst;
                    w_dpc4_nxt    = w_acc_pc4;
                    w_dvalid_nxt  = 1'b1;
                    w_pending_nxt = 1'b0;
                    w_state_nxt   = ST_FETCH;
                    if (w_redirect) begin
                        w_pc_nxt = w_npc;
                    end else if (r_pending) begin
                        w_pc_nxt = r_saved;
                    end else begin
                        w_pc_nxt = w_pc4;
                    end
                end else begin
                    // Delay slot still in flight: remember where to go after it
                    w_inst_nxt   = NOP_INST;
                    w_dvalid_nxt = 1'b0;
                    if (w_redirect) begin
                        w_saved_nxt   = w_npc;
                        w_pending_nxt = 1'b1;
                    end
                end
            end
            ST_DISCARD: begin
                if (wpcir) begin
                    w_inst_nxt   = NOP_INST;
                    w_dvalid_nxt = 1'b0;
                end
                if (imem_ready) begin
                    w_pc_nxt    = r_saved;
                    w_state_nxt = ST_FETCH;
                end
            end
            default: begin
                w_state_nxt = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= ST_FETCH;
            r_pc        <= RESET_PC;
            r_saved     <= 32'd0;
            r_pending   <= 1'b0;
            r_hold_inst <= 32'd0;
            r_hold_pc4  <= 32'd0;
            r_inst      <= NOP_INST;
            r_dpc4      <= 32'd0;
            r_dvalid    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_saved     <= w_saved_nxt;
            r_pending   <= w_pending_nxt;
            r_hold_inst <= w_hold_inst_nxt;
            r_hold_pc4  <= w_hold_pc4_nxt;
            r_inst      <= w_inst_nxt;
            r_dpc4      <= w_dpc4_nxt;
            r_dvalid    <= w_dvalid_nxt;
        end
    end

    // The discarded request keeps its address on the bus until it completes
    assign imem_req  = (r_state != ST_HOLD);
    assign imem_addr = r_pc;
    assign inst      = r_inst;
    assign dpc4      = r_dpc4;
    assign dvalid    = r_dvalid;

endmodule : pipe_fetch

`default_nettype wire

// File: tb/tb_pipe_fetch.sv
// ============================================================================
// Module      : tb_pipe_fetch
// Description : Self-checking bench for pipe_fetch: directed scenarios plus a
//               randomized run against a transaction-level fetch model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_fetch;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  pcsource = 2'b00;
    logic [31:0] bpc = 32'd0, da = 32'd0, jpc = 32'd0;
    logic        wpcir = 1'b1;
    logic        if_flush = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic [31:0] dpc4, inst;
    logic        dvalid;

    int errors = 0;
    int checks = 0;

    localparam logic [31:0] NOP = 32'h0000_0000;

    pipe_fetch u_dut (
        .clock      (clock),
        .reset      (reset),
        .pcsource   (pcsource),
        .bpc        (bpc),
        .da         (da),
        .jpc        (jpc),
        .wpcir      (wpcir),
        .if_flush   (if_flush),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .dpc4       (dpc4),
        .inst       (inst),
        .dvalid     (dvalid)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) + 32'h1234_5678;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        pcsource = 2'b00; if_flush = 1'b0; wpcir = 1'b1;
        imem_ready = 1'b0; imem_rdata = 32'd0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        checks++;
        if ({imem_req, imem_addr, inst, dpc4, dvalid} !== {1'b1, 32'h0, NOP, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: req=%b addr=%h inst=%h dpc4=%h dvalid=%b, required 1 00000000 %h 00000000 0",
                     imem_req, imem_addr, inst, dpc4, dvalid, NOP);
        end
        reset = 1'b0;
    endtask

    task automatic test_stream();
        do_reset();
        imem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            imem_rdata = 32'h11 * (i + 1);
            checks++;
            if (imem_addr !== 32'(4 * i)) begin
                errors++;
                $display("FAIL stream_addr%0d: got %h required %h", i, imem_addr, 32'(4 * i));
            end
            tick();
            checks++;
            if ({inst, dpc4, dvalid} !== {32'(32'h11 * (i + 1)), 32'(4 * i + 4), 1'b1}) begin
                errors++;
                $display("FAIL stream_ifid%0d: got inst=%h dpc4=%h dvalid=%b required %h %h 1",
                         i, inst, dpc4, dvalid, 32'(32'h11 * (i + 1)), 32'(4 * i + 4));
            end
        end
    endtask

    task automatic test_stall_hold();
        do_reset();
        imem_ready = 1'b1;
        imem_rdata = 32'h11; tick();
        imem_rdata = 32'h22; tick();
        imem_rdata = 32'h33; wpcir = 1'b0;
        tick();
        imem_ready = 1'b0; imem_rdata = 32'hBAD0_BAD0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({imem_req, inst, dpc4, dvalid} !== {1'b0, 32'h22, 32'h8, 1'b1}) begin
                errors++;
                $display("FAIL hold_frozen%0d: got req=%b inst=%h dpc4=%h dvalid=%b required 0 00000022 00000008 1",
                         i, imem_req, inst, dpc4, dvalid);
            end
            if (i < 2) tick();
        end
        wpcir = 1'b1;
        tick();
        checks++;
        if ({inst, dpc4, dvalid, imem_req, imem_addr} !== {32'h33, 32'hC, 1'b1, 1'b1, 32'hC}) begin
            errors++;
            $display("FAIL hold_release: got inst=%h dpc4=%h dvalid=%b req=%b addr=%h required 33 C 1 1 C",
                     inst, dpc4, dvalid, imem_req, imem_addr);
        end
    endtask

    task automatic test_flush_redirect();
        // continues from test_stall_hold: request at C outstanding
        imem_ready = 1'b0;
        pcsource = 2'b01; bpc = 32'h100; if_flush = 1'b1;
        tick();
        pcsource = 2'b00; if_flush = 1'b0;
        checks++;
        if ({inst, dvalid, dpc4, imem_req, imem_addr} !== {NOP, 1'b0, 32'hC, 1'b1, 32'hC}) begin
            errors++;
            $display("FAIL flush_bubble1: got inst=%h dvalid=%b dpc4=%h req=%b addr=%h required NOP 0 C 1 C",
                     inst, dvalid, dpc4, imem_req, imem_addr);
        end
        tick();
        checks++;
        if ({inst, dvalid, imem_addr} !== {NOP, 1'b0, 32'hC}) begin
            errors++;
            $display("FAIL flush_bubble2: got inst=%h dvalid=%b addr=%h required NOP 0 C", inst, dvalid, imem_addr);
        end
        imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        checks++;
        if ({inst, dvalid, imem_addr} !== {NOP, 1'b0, 32'h100}) begin
            errors++;
            $display("FAIL flush_drop: got inst=%h dvalid=%b addr=%h required NOP 0 100", inst, dvalid, imem_addr);
        end
        imem_rdata = 32'h55;
        tick();
        checks++;
        if ({inst, dpc4, dvalid} !== {32'h55, 32'h104, 1'b1}) begin
            errors++;
            $display("FAIL flush_target: got inst=%h dpc4=%h dvalid=%b required 55 104 1", inst, dpc4, dvalid);
        end
    endtask

    task automatic test_delay_slot();
        do_reset();
        imem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            imem_rdata = 32'hA0 + 32'(i);
            tick();
        end
        imem_ready = 1'b0;
        pcsource = 2'b11; jpc = 32'h200; if_flush = 1'b0;
        tick();
        pcsource = 2'b00;
        tick();
        imem_ready = 1'b1; imem_rdata = 32'h77;
        checks++;
        if ({dvalid, imem_addr} !== {1'b0, 32'h10}) begin
            errors++;
            $display("FAIL delay_wait: got dvalid=%b addr=%h required 0 10", dvalid, imem_addr);
        end
        tick();
        checks++;
        if ({inst, dpc4, dvalid, imem_addr} !== {32'h77, 32'h14, 1'b1, 32'h200}) begin
            errors++;
            $display("FAIL delay_slot: got inst=%h dpc4=%h dvalid=%b addr=%h required 77 14 1 200",
                     inst, dpc4, dvalid, imem_addr);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        imem_ready = 1'b1; imem_rdata = 32'h1;
        pcsource = 2'b11; jpc = 32'hFFFF_FFFC; if_flush = 1'b1;
        tick();
        pcsource = 2'b00; if_flush = 1'b0;
        checks++;
        if ({imem_addr, dvalid} !== {32'hFFFF_FFFC, 1'b0}) begin
            errors++;
            $display("FAIL wrap_target: got addr=%h dvalid=%b required FFFFFFFC 0", imem_addr, dvalid);
        end
        imem_rdata = 32'h99;
        tick();
        checks++;
        if ({inst, dpc4, dvalid, imem_addr} !== {32'h99, 32'h0, 1'b1, 32'h0}) begin
            errors++;
            $display("FAIL wrap_next: got inst=%h dpc4=%h dvalid=%b addr=%h required 99 0 1 0",
                     inst, dpc4, dvalid, imem_addr);
        end
    endtask

    task automatic test_reset_mid_discard();
        do_reset();
        imem_ready = 1'b1;
        imem_rdata = 32'h31; tick();
        imem_rdata = 32'h32; tick();
        imem_ready = 1'b0;
        pcsource = 2'b10; da = 32'h300; if_flush = 1'b1;
        tick();
        pcsource = 2'b00; if_flush = 1'b0;
        #2;
        reset = 1'b1;
        imem_ready = 1'b1; imem_rdata = 32'hBAD_BAD;
        #1;
        checks++;
        if ({inst, dvalid, dpc4, imem_req, imem_addr} !== {NOP, 1'b0, 32'h0, 1'b1, 32'h0}) begin
            errors++;
            $display("FAIL reset_async: got inst=%h dvalid=%b dpc4=%h req=%b addr=%h required NOP 0 0 1 0",
                     inst, dvalid, dpc4, imem_req, imem_addr);
        end
        tick();
        reset = 1'b0;
        imem_rdata = 32'h66;
        tick();
        checks++;
        if ({inst, dpc4, dvalid, imem_addr} !== {32'h66, 32'h4, 1'b1, 32'h4}) begin
            errors++;
            $display("FAIL reset_restart: got inst=%h dpc4=%h dvalid=%b addr=%h required 66 4 1 4",
                     inst, dpc4, dvalid, imem_addr);
        end
    endtask

    // Transaction-level model: the next sequential fetch address, whether its
    // instruction is already buffered, whether the outstanding read is dead,
    // and a deferred jump waiting behind a delay slot.
    task automatic test_random();
        logic [31:0] m_pc, m_drop_tgt, m_pend_tgt, tgt;
        logic [31:0] e_inst, e_dpc4;
        logic        e_dvalid, m_buf, m_drop, m_pend, have;
        do_reset();
        m_pc = 32'h0; m_buf = 1'b0; m_drop = 1'b0; m_pend = 1'b0;
        m_drop_tgt = 32'h0; m_pend_tgt = 32'h0;
        e_inst = NOP; e_dpc4 = 32'h0; e_dvalid = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            wpcir      = ($urandom_range(0, 3) != 0);
            imem_ready = 1'($urandom_range(0, 1));
            pcsource   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            if_flush   = 1'($urandom_range(0, 1));
            bpc = $urandom & 32'hFFFF_FFFC;
            da  = $urandom & 32'hFFFF_FFFC;
            jpc = $urandom & 32'hFFFF_FFFC;
            imem_rdata = mem_word(imem_addr);
            #1;
            checks++;
            if (imem_req !== !m_buf || (!m_buf && imem_addr !== m_pc)) begin
                errors++;
                $display("FAIL rand_req c%0d: got req=%b addr=%h required req=%b addr=%h",
                         cyc, imem_req, imem_addr, !m_buf, m_pc);
            end
            case (pcsource)
                2'b01:   tgt = bpc;
                2'b10:   tgt = da;
                2'b11:   tgt = jpc;
                default: tgt = m_pc + 32'd4;
            endcase
            have = m_buf || imem_ready;
            if (m_drop) begin
                if (wpcir) begin e_inst = NOP; e_dvalid = 1'b0; end
                if (imem_ready) begin m_drop = 1'b0; m_pc = m_drop_tgt; end
            end else if (!wpcir) begin
                if (imem_ready) m_buf = 1'b1;
            end else if (pcsource != 2'b00 && if_flush) begin
                e_inst = NOP; e_dvalid = 1'b0; m_pend = 1'b0; m_buf = 1'b0;
                if (have) m_pc = tgt;
                else begin m_drop = 1'b1; m_drop_tgt = tgt; end
            end else if (have) begin
                e_inst = mem_word(m_pc); e_dpc4 = m_pc + 32'd4; e_dvalid = 1'b1;
                m_buf = 1'b0;
                m_pc = (pcsource != 2'b00) ? tgt : (m_pend ? m_pend_tgt : m_pc + 32'd4);
                m_pend = 1'b0;
            end else begin
                e_inst = NOP; e_dvalid = 1'b0;
                if (pcsource != 2'b00) begin m_pend = 1'b1; m_pend_tgt = tgt; end
            end
            @(posedge clock);
            #1;
            checks++;
            if ({inst, dpc4, dvalid} !== {e_inst, e_dpc4, e_dvalid}) begin
                errors++;
                $display("FAIL rand_ifid c%0d: got inst=%h dpc4=%h dvalid=%b required %h %h %b",
                         cyc, inst, dpc4, dvalid, e_inst, e_dpc4, e_dvalid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall_hold();
        test_flush_redirect();
        test_delay_slot();
        test_wrap();
        test_reset_mid_discard();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_pipe_fetch

`default_nettype wire
